// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core state encodings and default instruction-memory geometry
package cpu_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LOAD = 2'b10,
    ST_HALT = 2'b11
  } state_e;
  localparam int IM_AW = 8;
  localparam int IM_DW = 32;
endpackage

// File: rtl/imem_load_sequencer_watchdog.sv
// run_watchdog: saturating RUN-cycle counter, watchdog compare and run_req edge detect
module run_watchdog #(
  parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        clr,
  input  logic        halt_req,
  input  logic        run_req,
  output logic        expire,
  output logic        run_rise,
  output logic [31:0] cycle_count,
  output logic        timeout
);
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        timeout_q, timeout_d, run_req_q;
  always_comb begin
    expire = run && cycle_count_q == MAX_CYCLES - 32'd1;
    run_rise = run_req && !run_req_q;
    cycle_count_d = clr ? '0 : run && cycle_count_q != '1 ? cycle_count_q + 32'd1 : cycle_count_q;
    timeout_d = clr ? 1'b0 : expire && !halt_req ? 1'b1 : timeout_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_count_q <= '0;
      timeout_q <= 1'b0;
      run_req_q <= 1'b0;
    end else begin
      cycle_count_q <= cycle_count_d;
      timeout_q <= timeout_d;
      run_req_q <= run_req;
    end
  end
  assign cycle_count = cycle_count_q;
  assign timeout = timeout_q;
endmodule

// File: rtl/imem_load_sequencer.sv
// imem_load_sequencer: IDLE/LOAD/RUN/HALT run controller and instruction-memory port arbiter
module imem_load_sequencer
  import cpu_pkg::*;
#(
  parameter int          AW         = IM_AW,
  parameter int          DW         = IM_DW,
  parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_start_load,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  input  logic          host_last,
  input  logic          run_req,
  input  logic          halt_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          im_wea,
  output logic [AW-1:0] im_addr,
  output logic [DW-1:0] im_din,
  output logic [1:0]    curr_state,
  output logic [AW:0]   load_count,
  output logic [31:0]   cycle_count,
  output logic          timeout,
  output logic          load_err
);
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  state_e        state_q, state_d;
  logic          wea_q, wea_d, load_err_q, load_err_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW:0]   load_count_q, load_count_d;
  logic          beat, room, start_clr, wd_clr, expire, run_rise, use_wr;
  run_watchdog #(.MAX_CYCLES(MAX_CYCLES)) u_wd (
    .clk(clk),
    .rst(rst),
    .run(state_q == ST_RUN),
    .clr(wd_clr),
    .halt_req(halt_req),
    .run_req(run_req),
    .expire(expire),
    .run_rise(run_rise),
    .cycle_count(cycle_count),
    .timeout(timeout)
  );
  always_comb begin
    beat = state_q == ST_LOAD && host_valid;
    room = load_count_q != FULL;
    start_clr = (state_q == ST_IDLE || state_q == ST_HALT) && host_start_load;
    wd_clr = !host_start_load && (state_q == ST_IDLE && run_req || state_q == ST_HALT && run_rise);
    wea_d = beat && room;
    waddr_d = wea_d ? host_addr : waddr_q;
    wdata_d = wea_d ? host_data : wdata_q;
    load_count_d = start_clr ? '0 : wea_d ? load_count_q + ONE : load_count_q;
    load_err_d = start_clr ? 1'b0 : beat && !room ? 1'b1 : load_err_q;
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = host_start_load ? ST_LOAD : run_req ? ST_RUN : ST_IDLE;
      ST_LOAD: state_d = beat && host_last ? ST_IDLE : ST_LOAD;
      ST_RUN:  state_d = halt_req || expire ? ST_HALT : run_req ? ST_RUN : ST_IDLE;
      ST_HALT: state_d = host_start_load ? ST_LOAD : run_rise ? ST_RUN : ST_HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wea_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      load_count_q <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wea_q <= wea_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      load_count_q <= load_count_d;
      load_err_q <= load_err_d;
    end
  end
  assign use_wr = state_q == ST_LOAD || wea_q;
  assign host_ready = state_q == ST_LOAD;
  assign im_wea = wea_q;
  assign im_addr = use_wr ? waddr_q : fetch_addr;
  assign im_din = use_wr ? wdata_q : '0;
  assign curr_state = state_q;
  assign load_count = load_count_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_imem_load_sequencer.sv
// tb_imem_load_sequencer: scoreboard bench for the run controller and IM arbiter
module tb_imem_load_sequencer;
  logic        clk = 1'b0;
  logic        rst, host_start_load, host_valid, host_last, run_req, halt_req;
  logic [7:0]  host_addr, fetch_addr;
  logic [31:0] host_data;
  logic        a_host_ready, a_im_wea, a_timeout, a_load_err;
  logic [7:0]  a_im_addr;
  logic [31:0] a_im_din, a_cycle_count;
  logic [1:0]  a_curr_state;
  logic [8:0]  a_load_count;
  logic        b_host_ready, b_im_wea, b_timeout, b_load_err;
  logic [1:0]  b_im_addr;
  logic [31:0] b_im_din, b_cycle_count;
  logic [1:0]  b_curr_state;
  logic [2:0]  b_load_count;
  typedef struct packed {logic [7:0] a; logic [31:0] d;} wr_t;
  wr_t qa[$], qb[$];
  wr_t wa, wb;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  imem_load_sequencer dut_a (
    .clk(clk), .rst(rst), .host_start_load(host_start_load), .host_valid(host_valid),
    .host_ready(a_host_ready), .host_addr(host_addr), .host_data(host_data), .host_last(host_last),
    .run_req(run_req), .halt_req(halt_req), .fetch_addr(fetch_addr), .im_wea(a_im_wea),
    .im_addr(a_im_addr), .im_din(a_im_din), .curr_state(a_curr_state), .load_count(a_load_count),
    .cycle_count(a_cycle_count), .timeout(a_timeout), .load_err(a_load_err)
  );
  imem_load_sequencer #(.AW(2), .MAX_CYCLES(32'd16)) dut_b (
    .clk(clk), .rst(rst), .host_start_load(host_start_load), .host_valid(host_valid),
    .host_ready(b_host_ready), .host_addr(host_addr[1:0]), .host_data(host_data), .host_last(host_last),
    .run_req(run_req), .halt_req(halt_req), .fetch_addr(fetch_addr[1:0]), .im_wea(b_im_wea),
    .im_addr(b_im_addr), .im_din(b_im_din), .curr_state(b_curr_state), .load_count(b_load_count),
    .cycle_count(b_cycle_count), .timeout(b_timeout), .load_err(b_load_err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic beat(input logic [7:0] a, input logic [31:0] d, input logic last, input logic to_a, input logic to_b);
    host_valid = 1'b1;
    host_addr = a;
    host_data = d;
    host_last = last;
    if (to_a) qa.push_back('{a: a, d: d});
    if (to_b) qb.push_back('{a: a, d: d});
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    host_last = 1'b0;
  endtask
  always @(negedge clk) begin
    if (a_im_wea === 1'b1) begin
      if (qa.size() == 0) chk("a_wr_spurious", a_im_wea, 0);
      else begin
        wa = qa.pop_front();
        chk("a_wr_addr", a_im_addr, wa.a);
        chk("a_wr_data", a_im_din, wa.d);
      end
    end
    if (b_im_wea === 1'b1) begin
      if (qb.size() == 0) chk("b_wr_spurious", b_im_wea, 0);
      else begin
        wb = qb.pop_front();
        chk("b_wr_addr", b_im_addr, wb.a[1:0]);
        chk("b_wr_data", b_im_din, wb.d);
      end
    end
  end
  initial begin
    rst = 1'b0;
    host_start_load = 1'b0;
    host_valid = 1'b0;
    host_last = 1'b0;
    run_req = 1'b0;
    halt_req = 1'b0;
    host_addr = '0;
    host_data = '0;
    fetch_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_state", a_curr_state, 0);
    chk("rst_wea", a_im_wea, 0);
    chk("rst_load_count", a_load_count, 0);
    chk("rst_cycle_count", a_cycle_count, 0);
    chk("rst_timeout", a_timeout, 0);
    chk("rst_load_err", a_load_err, 0);
    chk("rst_ready", a_host_ready, 0);
    chk("b_rst_state", b_curr_state, 0);
    host_start_load = 1'b1;
    @(posedge clk);
    #1 host_start_load = 1'b0;
    chk("load_state", a_curr_state, 2);
    chk("load_ready", a_host_ready, 1);
    beat(8'd0, 32'h20010005, 1'b0, 1'b1, 1'b1);
    beat(8'd1, 32'h2002000F, 1'b0, 1'b1, 1'b1);
    beat(8'd2, 32'hFC000000, 1'b1, 1'b1, 1'b1);
    chk("drain_state", a_curr_state, 0);
    chk("drain_addr", a_im_addr, 2);
    chk("load3_count", a_load_count, 3);
    chk("load3_err", a_load_err, 0);
    chk("b_load3_count", b_load_count, 3);
    chk("idle_ready", a_host_ready, 0);
    run_req = 1'b1;
    @(posedge clk);
    #1;
    chk("run_state", a_curr_state, 1);
    chk("b_run_state", b_curr_state, 1);
    chk("run_ready", a_host_ready, 0);
    for (int i = 0; i < 3; i++) begin
      fetch_addr = i[7:0];
      #1;
      chk("fetch_addr", a_im_addr, i);
      chk("fetch_wea", a_im_wea, 0);
      chk("fetch_din", a_im_din, 0);
    end
    repeat (15) @(posedge clk);
    #1 chk("b_wd_pre_state", b_curr_state, 1);
    @(posedge clk);
    #1;
    chk("b_wd_state", b_curr_state, 3);
    chk("b_wd_count", b_cycle_count, 16);
    chk("b_wd_timeout", b_timeout, 1);
    chk("a_still_run", a_curr_state, 1);
    repeat (23) @(posedge clk);
    #1 halt_req = 1'b1;
    @(posedge clk);
    #1 halt_req = 1'b0;
    chk("halt_state", a_curr_state, 3);
    chk("halt_count", a_cycle_count, 40);
    chk("halt_timeout", a_timeout, 0);
    chk("b_held_no_restart", b_curr_state, 3);
    chk("b_held_count", b_cycle_count, 16);
    chk("b_held_timeout", b_timeout, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("halt_count_hold", a_cycle_count, 40);
    chk("halt_state_hold", a_curr_state, 3);
    chk("halt_fetch_addr", a_im_addr, 2);
    run_req = 1'b0;
    @(posedge clk);
    #1 run_req = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_state", a_curr_state, 1);
    chk("b_restart_state", b_curr_state, 1);
    chk("b_restart_timeout", b_timeout, 0);
    chk("b_restart_count", b_cycle_count, 0);
    chk("restart_count", a_cycle_count, 0);
    repeat (15) @(posedge clk);
    #1 halt_req = 1'b1;
    @(posedge clk);
    #1 halt_req = 1'b0;
    chk("b_coinc_state", b_curr_state, 3);
    chk("b_coinc_timeout", b_timeout, 0);
    chk("b_coinc_count", b_cycle_count, 16);
    chk("coinc_state", a_curr_state, 3);
    chk("coinc_timeout", a_timeout, 0);
    host_start_load = 1'b1;
    @(posedge clk);
    #1 host_start_load = 1'b0;
    chk("reload_state", a_curr_state, 2);
    chk("b_reload_state", b_curr_state, 2);
    chk("b_reload_count", b_load_count, 0);
    chk("b_reload_ready", b_host_ready, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) run_req = 1'b0;
      beat(i[7:0], 32'h0BAD0000 | i[31:0], i == 4, 1'b1, i < 4);
    end
    chk("load5_state", a_curr_state, 0);
    chk("load5_count", a_load_count, 5);
    chk("load5_err", a_load_err, 0);
    chk("b_load5_state", b_curr_state, 0);
    chk("b_load5_count", b_load_count, 4);
    chk("b_load5_err", b_load_err, 1);
    host_start_load = 1'b1;
    run_req = 1'b1;
    @(posedge clk);
    #1;
    host_start_load = 1'b0;
    run_req = 1'b0;
    chk("both_req_state", a_curr_state, 2);
    chk("b_both_req_state", b_curr_state, 2);
    chk("b_both_req_err", b_load_err, 0);
    chk("b_both_req_count", b_load_count, 0);
    beat(8'h0A, 32'h12345678, 1'b0, 1'b1, 1'b1);
    host_valid = 1'b1;
    host_addr = 8'h0B;
    host_data = 32'hDEADBEEF;
    rst = 1'b0;
    @(posedge clk);
    #1 host_valid = 1'b0;
    chk("abort_state", a_curr_state, 0);
    chk("abort_wea", a_im_wea, 0);
    chk("abort_count", a_load_count, 0);
    chk("b_abort_state", b_curr_state, 0);
    chk("b_abort_wea", b_im_wea, 0);
    chk("b_abort_count", b_load_count, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
